// File: rtl/dcache_weights_arbiter.sv
// rtl/dcache_weights_arbiter.sv - round-robin arbiter sharing the dcache_weights read port (optional DCACHE_ARB_TIMEOUT_EN)
module dcache_weights_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [ADDR_W-1:0]         cache_addr_o,
  output logic                      cache_read_o,
  input  logic [DATA_W-1:0]         cache_data_i,
  input  logic                      cache_valid_i,
  output logic                      busy_o,
  output logic                      timeout_err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The wait counter is 8 bits wide, so the abort limit must fit in it.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("dcache_weights_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   winner_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [ADDR_W-1:0]  cache_addr_q;
  logic               cache_read_q;
  logic               busy_q;
`ifdef DCACHE_ARB_TIMEOUT_EN
  logic [7:0]         wait_cnt_q;
  logic               timeout_err_q;
`endif

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  grant_addr;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ; first asserted lane wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the winning lane's address slice.
  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_addr = req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // Access FSM: accept, one-cycle address setup, wait for cache, return response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      addr_q        <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      cache_addr_q  <= '0;
      cache_read_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef DCACHE_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_found) begin
            winner_q    <= grant_idx;
            addr_q      <= grant_addr;
            req_ready_q <= onehot(grant_idx);
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cache_addr_q <= addr_q;
          cache_read_q <= 1'b1;
`ifdef DCACHE_ARB_TIMEOUT_EN
          wait_cnt_q   <= '0;
`endif
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cache_valid_i) begin
            rsp_data_q   <= cache_data_i;
            cache_read_q <= 1'b0;
            state_q      <= ST_RESP;
          end
`ifdef DCACHE_ARB_TIMEOUT_EN
          else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
            // Abort: the winner still gets a response, carrying zero data.
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b1;
            cache_read_q  <= 1'b0;
            state_q       <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_q <= onehot(winner_q);
          rr_ptr_q    <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign cache_addr_o  = cache_addr_q;
  assign cache_read_o  = cache_read_q;
  assign busy_o        = busy_q;
`ifdef DCACHE_ARB_TIMEOUT_EN
  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule
